// File: rtl/register_dump_pkg.sv
// Shared widths and FSM state encoding for the register-file dump engine.
package register_dump_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int REGADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/register_dump.sv
// Walks a register range through one register-file read port and streams each value out with its index.
// Two cycles per beat when unstalled; stalls in READ without grant and in SEND until dumpReady.
module register_dump
  import register_dump_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dumpStart,
  input  logic [REGADDR_WIDTH-1:0] firstReg,
  input  logic [REGADDR_WIDTH-1:0] lastReg,
  input  logic                     dumpAbort,
  input  logic                     portGrant,
  input  logic [DATA_WIDTH-1:0]    regData,
  output logic [REGADDR_WIDTH-1:0] regSelect,
  output logic                     dumpValid,
  input  logic                     dumpReady,
  output logic [DATA_WIDTH-1:0]    dumpData,
  output logic [REGADDR_WIDTH-1:0] dumpIndex,
  output logic                     dumpLast,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    checksum
);

  dump_state_t state, state_nxt;

  logic [REGADDR_WIDTH-1:0] cur;
  logic [REGADDR_WIDTH-1:0] last_reg;
  logic [DATA_WIDTH-1:0]    run_xor;
  logic                     beat_hs;

  assign beat_hs   = dumpValid & dumpReady;
  assign regSelect = cur;
  assign busy      = (state != DUMP_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DUMP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DUMP_IDLE: begin
        if (dumpStart) begin
          state_nxt = (firstReg > lastReg) ? DUMP_DONE : DUMP_READ;
        end
      end
      DUMP_READ: begin
        if (dumpAbort) begin
          state_nxt = DUMP_IDLE;
        end else if (portGrant) begin
          state_nxt = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        // Abort wins over a coincident handshake; that beat is dropped.
        if (dumpAbort) begin
          state_nxt = DUMP_IDLE;
        end else if (beat_hs) begin
          state_nxt = dumpLast ? DUMP_DONE : DUMP_READ;
        end
      end
      DUMP_DONE: begin
        state_nxt = DUMP_IDLE;
      end
      default: begin
        state_nxt = DUMP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= '0;
      last_reg  <= '0;
      run_xor   <= '0;
      dumpValid <= 1'b0;
      dumpData  <= '0;
      dumpIndex <= '0;
      dumpLast  <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        DUMP_IDLE: begin
          if (dumpStart) begin
            cur      <= firstReg;
            last_reg <= lastReg;
            run_xor  <= '0;
          end
        end
        DUMP_READ: begin
          if (!dumpAbort && portGrant) begin
            dumpData  <= regData;
            dumpIndex <= cur;
            dumpLast  <= (cur == last_reg);
            dumpValid <= 1'b1;
          end
        end
        DUMP_SEND: begin
          if (dumpAbort) begin
            dumpValid <= 1'b0;
          end else if (beat_hs) begin
            dumpValid <= 1'b0;
            run_xor   <= run_xor ^ dumpData;
            // The final beat never increments, so cur cannot wrap past 31.
            if (!dumpLast) begin
              cur <= cur + REGADDR_WIDTH'(1);
            end
          end
        end
        DUMP_DONE: begin
          done     <= 1'b1;
          checksum <= run_xor;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump.sv
// Randomized and directed bench for register_dump; a scoreboard checks every accepted beat and done pulse.
module tb_register_dump;
  import register_dump_pkg::*;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] dat;
    logic        lst;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dumpStart, dumpAbort, portGrant, dumpReady;
  logic [4:0]  firstReg, lastReg, regSelect, dumpIndex;
  logic [31:0] regData, dumpData, checksum;
  logic        dumpValid, dumpLast, busy, done;

  logic [31:0] rf [32];
  beat_t       exp_q[$];
  logic [31:0] cs_q[$];
  logic [31:0] last_cs;

  int n_cmp = 0;
  int n_err = 0;

  logic        prev_vld, prev_rdy;
  logic [37:0] prev_beat;

  always #5 clk = ~clk;

  assign regData = rf[regSelect];

  register_dump dut (
    .clk(clk), .reset(reset), .dumpStart(dumpStart), .firstReg(firstReg), .lastReg(lastReg),
    .dumpAbort(dumpAbort), .portGrant(portGrant), .regData(regData), .regSelect(regSelect),
    .dumpValid(dumpValid), .dumpReady(dumpReady), .dumpData(dumpData), .dumpIndex(dumpIndex),
    .dumpLast(dumpLast), .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a dump of [f..l] yields rf[f..l] in order, last flag on l, checksum = XOR of them.
  task automatic push_expect(input logic [4:0] f, input logic [4:0] l);
    logic [31:0] cs;
    beat_t b;
    cs = 32'd0;
    if (f <= l) begin
      for (int i = f; i <= l; i++) begin
        b.idx = 5'(i);
        b.dat = rf[i];
        b.lst = (i == l);
        exp_q.push_back(b);
        cs = cs ^ rf[i];
      end
    end
    cs_q.push_back(cs);
    last_cs = cs;
  endtask

  always @(negedge clk) begin
    beat_t b;
    logic [31:0] c;
    if (reset) begin
      if (dumpValid && prev_vld && !prev_rdy)
        check("stall_stable", 64'({dumpIndex, dumpData, dumpLast}), 64'(prev_beat));
      if (dumpValid && dumpReady && !dumpAbort) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_beat: got index %0d data %h, none expected", dumpIndex, dumpData);
        end else begin
          b = exp_q.pop_front();
          check("beat", 64'({dumpIndex, dumpData, dumpLast}), 64'({b.idx, b.dat, b.lst}));
        end
      end
      if (done) begin
        if (cs_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_done: got done with checksum %h, none expected", checksum);
        end else begin
          c = cs_q.pop_front();
          check("checksum", 64'(checksum), 64'(c));
        end
      end
      prev_vld  = dumpValid;
      prev_rdy  = dumpReady;
      prev_beat = {dumpIndex, dumpData, dumpLast};
    end else begin
      prev_vld = 1'b0;
    end
  end

  // mode 0: grant/ready high; 1: random; 2: ready stall on beat 2; 3: grant gap on READ of reg 2
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode);
    int cyc, stall, g_state, g_cnt, exp_cyc;
    bit got, saw_vld;
    cyc = 0; stall = 0; g_state = 0; g_cnt = 0; got = 0; saw_vld = 0;
    push_expect(f, l);
    firstReg = f; lastReg = l; dumpStart = 1'b1;
    while (cyc < 400 && !got) begin
      @(posedge clk); #1;
      cyc++;
      dumpStart = 1'b0;
      if (dumpValid) saw_vld = 1'b1;
      if (done) begin
        got = 1'b1;
      end else if (mode == 1) begin
        portGrant = ($urandom_range(0, 3) != 0);
        dumpReady = ($urandom_range(0, 3) != 0);
        if (busy && $urandom_range(0, 7) == 0) begin
          dumpStart = 1'b1;
          firstReg  = 5'($urandom);
          lastReg   = 5'($urandom);
        end
      end else if (mode == 2) begin
        if (dumpValid && dumpIndex == 5'd2 && stall < 5) begin
          dumpReady = 1'b0;
          stall++;
        end else begin
          dumpReady = 1'b1;
        end
      end else if (mode == 3) begin
        if (g_state == 0 && busy && !dumpValid && regSelect == 5'd2) begin
          portGrant = 1'b0; g_cnt = 1; g_state = 1;
        end else if (g_state == 1) begin
          check("grant_low_no_capture", 64'(dumpValid), 64'd0);
          if (g_cnt == 4) begin
            portGrant = 1'b1; g_state = 2;
          end else begin
            g_cnt++;
          end
        end else if (g_state == 2) begin
          check("grant_rise_beat", 64'({dumpValid, dumpIndex}), 64'({1'b1, 5'd2}));
          g_state = 3;
        end
      end
    end
    check("done_seen", 64'(got), 64'd1);
    if (mode == 0) begin
      exp_cyc = (f > l) ? 2 : 2 * (int'(l) - int'(f) + 1) + 2;
      check("done_latency", 64'(cyc), 64'(exp_cyc));
    end
    if (f > l) check("zero_no_valid", 64'(saw_vld), 64'd0);
    if (mode == 2) check("stall_cycles", 64'(stall), 64'd5);
    if (mode == 3) check("grant_sequence", 64'(g_state), 64'd3);
    portGrant = 1'b1; dumpReady = 1'b1; dumpStart = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_regSelect"}, 64'(regSelect), 64'd0);
    check({tag, "_dumpValid"}, 64'(dumpValid), 64'd0);
    check({tag, "_dumpData"},  64'(dumpData),  64'd0);
    check({tag, "_dumpIndex"}, 64'(dumpIndex), 64'd0);
    check({tag, "_dumpLast"},  64'(dumpLast),  64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_checksum"},  64'(checksum),  64'd0);
  endtask

  task automatic fill_rf();
    rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [4:0] f, l;
    reset = 1'b0; dumpStart = 1'b0; dumpAbort = 1'b0; portGrant = 1'b1; dumpReady = 1'b1;
    firstReg = '0; lastReg = '0; last_cs = '0;
    prev_vld = 1'b0; prev_rdy = 1'b0; prev_beat = '0;
    fill_rf();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed basic range
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h44;
    run_dump(5'd1, 5'd3, 0);
    check("basic_checksum", 64'(checksum), 64'h77);
    run_dump(5'd1, 5'd3, 2);
    check("stall_checksum", 64'(checksum), 64'h77);
    run_dump(5'd1, 5'd3, 3);

    // Abort during SEND of reg 5, then full restart
    fill_rf();
    for (int i = 0; i < 5; i++) exp_q.push_back('{idx: 5'(i), dat: rf[i], lst: 1'b0});
    firstReg = 5'd0; lastReg = 5'd31; dumpStart = 1'b1;
    cyc = 0;
    while (cyc < 100 && !(dumpValid && dumpIndex == 5'd5)) begin
      @(posedge clk); #1;
      cyc++;
      dumpStart = 1'b0;
    end
    check("abort_reached_reg5", 64'({dumpValid, dumpIndex}), 64'({1'b1, 5'd5}));
    dumpAbort = 1'b1;
    @(posedge clk); #1;
    dumpAbort = 1'b0;
    check("abort_idle", 64'({busy, dumpValid}), 64'd0);
    check("abort_checksum_kept", 64'(checksum), 64'(last_cs));
    repeat (5) @(posedge clk);
    #1;
    check("abort_queue_drained", 64'(exp_q.size()), 64'd0);
    run_dump(5'd0, 5'd31, 0);

    // Zero-beat dump
    run_dump(5'd7, 5'd3, 0);
    check("zero_checksum", 64'(checksum), 64'd0);

    // Randomized ranges with random grant/ready and ignored restarts
    for (int n = 0; n < 20; n++) begin
      fill_rf();
      f = 5'($urandom);
      l = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(int'(f), 31));
      run_dump(f, l, 1);
    end

    // Asynchronous reset in the middle of SEND
    fill_rf();
    push_expect(5'd1, 5'd3);
    firstReg = 5'd1; lastReg = 5'd3; dumpStart = 1'b1; dumpReady = 1'b0;
    cyc = 0;
    while (cyc < 50 && !dumpValid) begin
      @(posedge clk); #1;
      cyc++;
      dumpStart = 1'b0;
    end
    check("reset_reached_send", 64'(dumpValid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    exp_q.delete();
    cs_q.delete();
    last_cs = '0;
    dumpReady = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_dump(5'd2, 5'd4, 0);

    repeat (3) @(posedge clk);
    #1;
    check("final_beats_drained", 64'(exp_q.size()), 64'd0);
    check("final_dones_drained", 64'(cs_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
